// File: rtl/l1i_cache_pkg.sv
// Shared types and address-split helpers for the l1i_cache instruction cache.
package l1i_pkg;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 256;
  localparam int OFF_W  = 5;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Results are full-width; callers size-cast them to their index/tag width.
  function automatic addr_t get_index(input addr_t addr, input int idx_w);
    return (addr >> OFF_W) & ((addr_t'(1) << idx_w) - addr_t'(1));
  endfunction

  function automatic addr_t get_tag(input addr_t addr, input int idx_w);
    return addr >> (OFF_W + idx_w);
  endfunction

endpackage

// File: rtl/l1i_cache_if.sv
// Fill, redirect and fetch-delivery signals of l1i_cache, named from the cache's side.
interface l1i_cache_if;
  import l1i_pkg::*;

  logic  writeEnable_i;
  addr_t writeAddress_i;
  line_t block_i;
  logic  shouldBranch_i;
  addr_t branchOffset_i;
  logic  branchDirection_i;
  addr_t PC_o;
  line_t data_o;
  logic  enable_o;

  modport master (
    output writeEnable_i, writeAddress_i, block_i,
    output shouldBranch_i, branchOffset_i, branchDirection_i,
    input  PC_o, data_o, enable_o
  );

  modport slave (
    input  writeEnable_i, writeAddress_i, block_i,
    input  shouldBranch_i, branchOffset_i, branchDirection_i,
    output PC_o, data_o, enable_o
  );

endinterface

// File: rtl/l1i_cache_line_store.sv
// Direct-mapped valid/tag/data store: one write port, one combinational read port.
// L1I_WRITE_BYPASS_EN forwards a same-cycle matching fill to the read port.
module l1i_line_store
  import l1i_pkg::*;
#(
  parameter int NUM_LINES = 64
) (
  input  logic  clock_i,
  input  logic  reset_i,
  input  logic  we_i,
  input  addr_t waddr_i,
  input  line_t wdata_i,
  input  addr_t raddr_i,
  output logic  hit_o,
  output line_t rline_o
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  line_t                data_q [NUM_LINES];

  logic [IDX_W-1:0] widx, ridx;
  logic [TAG_W-1:0] wtag, rtag;
  logic             stored_hit;

  assign widx = IDX_W'(get_index(waddr_i, IDX_W));
  assign wtag = TAG_W'(get_tag(waddr_i, IDX_W));
  assign ridx = IDX_W'(get_index(raddr_i, IDX_W));
  assign rtag = TAG_W'(get_tag(raddr_i, IDX_W));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) valid_q <= '0;
    else if (we_i) valid_q[widx] <= 1'b1;
  end

  // NOTE: tag and data arrays are deliberately not reset; a line is only ever
  // read through its valid bit, and an unreset array can map onto plain RAM.
  always_ff @(posedge clock_i) begin
    if (we_i) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata_i;
    end
  end

  assign stored_hit = valid_q[ridx] && (tag_q[ridx] == rtag);

`ifdef L1I_WRITE_BYPASS_EN
  logic fwd;
  assign fwd     = we_i && (widx == ridx) && (wtag == rtag);
  assign hit_o   = stored_hit || fwd;
  assign rline_o = fwd ? wdata_i : data_q[ridx];
`else
  assign hit_o   = stored_hit;
  assign rline_o = data_q[ridx];
`endif

endmodule

// File: rtl/l1i_cache.sv
// Direct-mapped L1 instruction cache with integrated fetch PC and relative branch redirect.
// Optional same-cycle fill forwarding is enabled by defining L1I_WRITE_BYPASS_EN.
module l1i_cache
  import l1i_pkg::*;
#(
  parameter int NUM_LINES = 64
) (
  input logic        clock_i,
  input logic        reset_i,
  l1i_cache_if.slave bus
);

  localparam int LINE_ADDR_W = ADDR_W - OFF_W;

  addr_t fetch_pc_q, fetch_pc_d;
  addr_t pc_q, pc_d;
  line_t data_q, data_d;
  logic  enable_q, enable_d;

  logic                   hit;
  line_t                  line;
  addr_t                  branch_target;
  logic [LINE_ADDR_W-1:0] next_line;

  l1i_line_store #(.NUM_LINES(NUM_LINES)) u_store (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .we_i    (bus.writeEnable_i),
    .waddr_i (bus.writeAddress_i),
    .wdata_i (bus.block_i),
    .raddr_i (fetch_pc_q),
    .hit_o   (hit),
    .rline_o (line)
  );

  // Redirects are relative to the last delivered line, not the lookahead fetch PC.
  assign branch_target = bus.branchDirection_i ? pc_q - bus.branchOffset_i
                                               : pc_q + bus.branchOffset_i;
  assign next_line     = fetch_pc_q[ADDR_W-1:OFF_W] + LINE_ADDR_W'(1);

  // NOTE: every next-state variable takes its hold value first, so no path
  // through the branches below can leave one unassigned and infer a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    data_d     = data_q;
    enable_d   = 1'b0;
    if (bus.shouldBranch_i) begin
      fetch_pc_d = branch_target;
    end else if (hit) begin
      data_d     = line;
      pc_d       = fetch_pc_q;
      enable_d   = 1'b1;
      fetch_pc_d = {next_line, {OFF_W{1'b0}}};
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_pc_q <= '0;
      pc_q       <= '0;
      data_q     <= '0;
      enable_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      data_q     <= data_d;
      enable_q   <= enable_d;
    end
  end

  assign bus.PC_o     = pc_q;
  assign bus.data_o   = data_q;
  assign bus.enable_o = enable_q;

endmodule

// File: tb/tb_l1i_cache.sv
// Directed self-checking bench for l1i_cache (default build; bypass-aware where fills race lookups).
module tb_l1i_cache;
  import l1i_pkg::*;

  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  l1i_cache_if bus ();

  l1i_cache #(.NUM_LINES(64)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clock_i = ~clock_i;

  localparam line_t PAT_A5 = {32{8'hA5}};
  localparam line_t PAT_5A = {32{8'h5A}};
  localparam line_t PAT_C3 = {32{8'hC3}};
  localparam line_t PAT_3C = {32{8'h3C}};
  localparam line_t PAT_96 = {32{8'h96}};
  localparam line_t PAT_77 = {32{8'h77}};

  task automatic check(input string tag, input logic [LINE_W-1:0] actual,
                       input logic [LINE_W-1:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic expect_out(input string tag, input logic en, input addr_t pc, input line_t data);
    check({tag, ".en"},   LINE_W'(bus.enable_o), LINE_W'(en));
    check({tag, ".pc"},   LINE_W'(bus.PC_o),     LINE_W'(pc));
    check({tag, ".data"}, bus.data_o,            data);
  endtask

  // Inputs set before a tick are sampled at its rising edge; outputs are read 1 ns later.
  task automatic tick();
    @(posedge clock_i);
    #1;
    bus.writeEnable_i  = 1'b0;
    bus.shouldBranch_i = 1'b0;
  endtask

  task automatic fill(input addr_t addr, input line_t data);
    bus.writeEnable_i  = 1'b1;
    bus.writeAddress_i = addr;
    bus.block_i        = data;
  endtask

  task automatic branch(input addr_t offset, input logic backward);
    bus.shouldBranch_i    = 1'b1;
    bus.branchOffset_i    = offset;
    bus.branchDirection_i = backward;
  endtask

  initial begin
    bus.writeEnable_i     = 1'b0;
    bus.writeAddress_i    = '0;
    bus.block_i           = '0;
    bus.shouldBranch_i    = 1'b0;
    bus.branchOffset_i    = '0;
    bus.branchDirection_i = 1'b0;

    #2 reset_i = 1'b1;
    #1 expect_out("reset", 1'b0, 16'h0000, '0);
    tick();
    reset_i = 1'b0;

    for (int i = 0; i < 66; i++) begin
      tick();
      expect_out("idle", 1'b0, 16'h0000, '0);
    end

    // Fill line 0x0020, then line 0x0000 while it is being looked up.
    fill(16'h0020, PAT_5A);
    tick();
    expect_out("fill20", 1'b0, 16'h0000, '0);
    fill(16'h0000, PAT_A5);
    tick();
`ifdef L1I_WRITE_BYPASS_EN
    expect_out("hit00", 1'b1, 16'h0000, PAT_A5);
`else
    expect_out("fill00_race", 1'b0, 16'h0000, '0);
    tick();
    expect_out("hit00", 1'b1, 16'h0000, PAT_A5);
`endif
    tick();
    expect_out("hit20", 1'b1, 16'h0020, PAT_5A);
    tick();
    expect_out("miss40", 1'b0, 16'h0020, PAT_5A);
    tick();
    expect_out("stall40", 1'b0, 16'h0020, PAT_5A);

    // Backward 0x20 from PC_o 0x0020: bubble, then line 0x0000.
    branch(16'h0020, 1'b1);
    tick();
    expect_out("bwd_bubble", 1'b0, 16'h0020, PAT_5A);
    tick();
    expect_out("bwd_hit00", 1'b1, 16'h0000, PAT_A5);

    // Branch overrides a pending hit at 0x0020; fill 0x0100 on the same edge.
    branch(16'h0100, 1'b0);
    fill(16'h0100, PAT_C3);
    tick();
    expect_out("fwd_bubble", 1'b0, 16'h0000, PAT_A5);
    tick();
    expect_out("fwd_hit100", 1'b1, 16'h0100, PAT_C3);
    tick();
    expect_out("miss120", 1'b0, 16'h0100, PAT_C3);

    // Back to 0x0000, then backward 0x20 wraps the fetch PC to 0xFFE0.
    branch(16'h0100, 1'b1);
    tick();
    tick();
    expect_out("hit00_b", 1'b1, 16'h0000, PAT_A5);
    branch(16'h0020, 1'b1);
    tick();
    expect_out("wrap_bubble", 1'b0, 16'h0000, PAT_A5);
    tick();
    expect_out("missFFE0", 1'b0, 16'h0000, PAT_A5);

    // Fill the stalled line in the cycle it is looked up.
    fill(16'hFFE0, PAT_3C);
    tick();
`ifdef L1I_WRITE_BYPASS_EN
    expect_out("hitFFE0", 1'b1, 16'hFFE0, PAT_3C);
`else
    expect_out("fillFFE0_race", 1'b0, 16'h0000, PAT_A5);
    tick();
    expect_out("hitFFE0", 1'b1, 16'hFFE0, PAT_3C);
`endif
    tick();
    expect_out("seq_wrap00", 1'b1, 16'h0000, PAT_A5);

    // Tag conflict: 0x0800 evicts 0x0000 while 0x0020 is delivered.
    fill(16'h0800, PAT_96);
    tick();
    expect_out("hit20_b", 1'b1, 16'h0020, PAT_5A);
    branch(16'h0020, 1'b1);
    tick();
    tick();
    expect_out("conflict_miss00", 1'b0, 16'h0020, PAT_5A);
    branch(16'h07E0, 1'b0);
    tick();
    tick();
    expect_out("hit800", 1'b1, 16'h0800, PAT_96);
    tick();
    expect_out("miss820", 1'b0, 16'h0800, PAT_96);

    // Unaligned target 0x0105: PC_o reports it, next fetch is aligned 0x0120.
    branch(16'h06FB, 1'b1);
    tick();
    tick();
    expect_out("unaligned_hit", 1'b1, 16'h0105, PAT_C3);
    tick();
    expect_out("unaligned_next", 1'b0, 16'h0105, PAT_C3);

    // Reach PC_o = 0x0040, then reset asynchronously mid-cycle.
    branch(16'h00C5, 1'b1);
    fill(16'h0040, PAT_77);
    tick();
    tick();
    expect_out("hit40", 1'b1, 16'h0040, PAT_77);
    #2 reset_i = 1'b1;
    #1 expect_out("async_reset", 1'b0, 16'h0000, '0);
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("post_reset", 1'b0, 16'h0000, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l1i_cache.md
Name: l1i_cache

Overview:
- Direct-mapped level-1 instruction cache with an integrated fetch program counter, sitting at the front of the fetch stage.
- Each cycle it looks up the current fetch PC and, on a hit, delivers the whole 256-bit line with its PC and a valid strobe to decode.
- Lines are filled externally through a write port.
- Branch redirects from later stages reload the fetch PC with a relative target.

Parameters:
- NUM_LINES, 64, number of cache lines (power of two, ≥2); index width IDX_W = log2(NUM_LINES).
- ADDR_W, 16, byte-address width of PC and write address.
- LINE_W, 256, line width in bits (32 bytes); offset width OFF_W = 5.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- writeEnable_i  in  1  line-fill strobe.
- writeAddress_i  in  16  byte address of the line being filled; low 5 bits ignored.
- block_i  in  256  fill data.
- shouldBranch_i  in  1  redirect request.
- branchOffset_i  in  16  unsigned branch distance in bytes.
- branchDirection_i  in  1  0 = forward (add), 1 = backward (subtract).
- PC_o  out  16  byte address of the line delivered on data_o.
- data_o  out  256  fetched line.
- enable_o  out  1  data_o/PC_o valid this cycle.

Behaviour:
- Address split: tag = PC[15:5+IDX_W], index = PC[5+IDX_W-1:5], offset = PC[4:0]. With defaults the tag is 5 bits.
- Storage: per line a valid bit, a tag and 256 data bits.
- Internal fetchPC register, 16 bits.
- Reset (async, active-high):
  - all valid bits cleared; fetchPC = 0;
  - PC_o = 0, data_o = 0, enable_o = 0.
  - Tag and data arrays need not be cleared.
  - Reset mid-run discards any in-flight fetch; the first lookup after release is at PC 0.
- Hit = valid[index(fetchPC)] && tag matches tag(fetchPC). Lookup is combinational; outputs are registered, so latency is 1 cycle.
- Each rising edge, in priority order:
  1. shouldBranch_i = 1:
     - fetchPC <= PC_o + branchOffset_i (direction 0) or PC_o − branchOffset_i (direction 1), modulo 2^16;
     - enable_o <= 0 (one bubble); PC_o and data_o hold.
  2. Else on hit:
     - data_o <= line, PC_o <= fetchPC, enable_o <= 1;
     - fetchPC <= {fetchPC[15:5] + 1, 5'b0}, i.e. the next line boundary, wrapping 0xFFE0 → 0x0000.
  3. Else on miss:
     - enable_o <= 0; fetchPC, PC_o and data_o hold.
     - The fetch stalls until a fill makes the line valid.
- Fill: when writeEnable_i = 1, at the edge line index(writeAddress_i) receives block_i and tag(writeAddress_i), and its valid bit is set. A fill overwrites any existing line, including a valid line with a different tag.
- A fill and a lookup to the same line in the same cycle: the lookup sees the old contents (without the optional feature). The hit occurs on the following cycle.
- A fill and a branch in the same cycle are independent; both take effect.
- An unaligned branch target is permitted. The lookup uses the upper bits only; PC_o reports the full target; the next sequential PC is aligned.
- With no fills, the cache stays idle: enable_o = 0 and PC_o = 0 indefinitely.

Optional Feature:
- Macro L1I_WRITE_BYPASS_EN.
- Defined: a same-cycle fill whose index and tag match fetchPC counts as a hit. block_i is forwarded to data_o at that edge, with enable_o = 1 and fetchPC advancing, saving one stall cycle.
- Undefined: no forwarding; behaviour as stated above.

Decomposition:
- Package l1i_pkg: ADDR_W, LINE_W, OFF_W constants; typedef line_t (256-bit); typedef addr_t (16-bit); functions get_index/get_tag.
- One sub-module, l1i_line_store: valid/tag/data arrays with an async-clear valid vector, one write port and one combinational read port returning {hit, line}.
- The top level holds fetchPC, the branch adder and the output registers.

Test Plan:
- Reset, then 66 clocks with no stimulus -> enable_o = 0, PC_o = 0x0000, data_o = 0 throughout.
- Fill 0x0000 with 0xA5..A5 and 0x0020 with 0x5A..5A, then run -> enable_o = 1 with PC_o = 0x0000 then 0x0020, correct data; next cycle miss at 0x0040 -> enable_o = 0 and stall.
- After the PC_o = 0x0020 hit, assert shouldBranch_i, offset 0x0020, direction 1 -> one bubble, then PC_o = 0x0000 hit. Also forward offset 0x0100 from 0x0000 with line 0x0100 filled -> PC_o = 0x0100.
- Wrap cases:
  - backward offset 0x0020 from PC_o = 0x0000 -> fetchPC = 0xFFE0 (miss unless filled);
  - sequential from a filled 0xFFE0 -> next PC 0x0000.
- Tag conflict: fill 0x0000, then fill 0x0800 (same index, default config) -> fetch at 0x0000 misses. Same-cycle fill of the stalled line -> hit one cycle later, or the same edge with L1I_WRITE_BYPASS_EN.
- Reset asserted mid-run with PC_o = 0x0040 -> outputs 0 immediately; all lines invalid; fetch restarts at 0x0000 with misses.
